// File: rtl/plru_pkg.sv
// Shared types and constants for the 16-way binary-tree PLRU state store.
package plru_pkg;

    localparam int WAY_BITS  = 4;
    localparam int NUM_WAYS  = 2**WAY_BITS;
    localparam int PLRU_BITS = NUM_WAYS - 1;

    typedef logic [PLRU_BITS-1:0] plru_word_t;
    typedef logic [WAY_BITS-1:0]  way_t;
    // Heap node index; the largest node (14) fits in WAY_BITS bits.
    typedef logic [WAY_BITS-1:0]  node_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/plru_array_if.sv
// Lookup / update / clear bus between the cache control FSM and plru_array.
// PLRU_INVALID_FIRST_EN adds the valid_mask input sampled with rd_en.
interface plru_array_if #(
    parameter int S_INDEX = 4
) ();
    import plru_pkg::*;

    logic               rd_en;
    logic [S_INDEX-1:0] rd_index;
    way_t               victim_way;
    plru_word_t         plru_out;
    logic               rd_valid;
    logic               upd_en;
    logic [S_INDEX-1:0] upd_index;
    way_t               upd_way;
    logic               clear_req;
    logic               busy;
`ifdef PLRU_INVALID_FIRST_EN
    logic [NUM_WAYS-1:0] valid_mask;

    modport master (
        output rd_en, rd_index, upd_en, upd_index, upd_way, clear_req, valid_mask,
        input  victim_way, plru_out, rd_valid, busy
    );
    modport slave (
        input  rd_en, rd_index, upd_en, upd_index, upd_way, clear_req, valid_mask,
        output victim_way, plru_out, rd_valid, busy
    );
`else
    modport master (
        output rd_en, rd_index, upd_en, upd_index, upd_way, clear_req,
        input  victim_way, plru_out, rd_valid, busy
    );
    modport slave (
        input  rd_en, rd_index, upd_en, upd_index, upd_way, clear_req,
        output victim_way, plru_out, rd_valid, busy
    );
`endif
endinterface

// File: rtl/plru_update.sv
// Combinational tree update: marks every node on the accessed way's path as
// pointing away from that way.
module plru_update
    import plru_pkg::*;
(
    input  plru_word_t word_in,
    input  way_t       way,
    output plru_word_t word_out
);

    node_t node;
    way_t  way_sh;
    logic  b;

    always_comb begin
        word_out = word_in;
        node     = '0;
        way_sh   = way;
        b        = 1'b0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            b              = way_sh[WAY_BITS-1];
            word_out[node] = ~b;
            node           = (node << 1) + node_t'(1) + node_t'(b);
            way_sh         = way_sh << 1;
        end
    end

endmodule

// File: rtl/plru_victim.sv
// Combinational tree walk: follows the stored bits from the root, MSB first,
// to the pseudo-least-recently-used way.
module plru_victim
    import plru_pkg::*;
(
    input  plru_word_t word_in,
    output way_t       victim
);

    node_t node;
    logic  b;

    always_comb begin
        victim = '0;
        node   = '0;
        b      = 1'b0;
        for (int lvl = 0; lvl < WAY_BITS; lvl++) begin
            b      = word_in[node];
            victim = {victim[WAY_BITS-2:0], b};
            node   = (node << 1) + node_t'(1) + node_t'(b);
        end
    end

endmodule

// File: rtl/plru_array.sv
// Per-set PLRU word store with write-first lookup, registered victim and a
// sequential clear engine. PLRU_INVALID_FIRST_EN prefers the lowest invalid way.
module plru_array
    import plru_pkg::*;
#(
    parameter int S_INDEX = 4
) (
    input  logic          clk,
    input  logic          rst,
    plru_array_if.slave   bus
);

    localparam int NUM_SETS = 2**S_INDEX;
    typedef logic [S_INDEX-1:0] idx_t;

    clr_state_t state_reg, state_next;
    idx_t       ptr_reg, ptr_next;
    logic       clearing;

    plru_word_t set_words [NUM_SETS];
    plru_word_t upd_cur, upd_new, rd_word;
    way_t       tree_way, victim_sel;
    logic       upd_fire;

    plru_word_t plru_reg;
    way_t       victim_reg;
    logic       rd_valid_reg;

    // ---------------- clear FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (bus.clear_req) begin
                    state_next = CLEAR;
                    ptr_next   = '0;
                end
            end
            CLEAR: begin
                ptr_next = ptr_reg + idx_t'(1);
                if (&ptr_reg) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        clearing = (state_reg == CLEAR);
    end

    // ---------------- update path ----------------
    assign upd_fire = bus.upd_en && !clearing;
    assign upd_cur  = set_words[bus.upd_index];

    plru_update u_update (
        .word_in  (upd_cur),
        .way      (bus.upd_way),
        .word_out (upd_new)
    );

    // Each set is its own register so reset can zero the whole array at once.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SETS; gi++) begin : g_set
            plru_word_t word_reg;
            always_ff @(posedge clk) begin
                if (rst)
                    word_reg <= '0;
                else if (clearing && ptr_reg == idx_t'(gi))
                    word_reg <= '0;
                else if (upd_fire && bus.upd_index == idx_t'(gi))
                    word_reg <= upd_new;
            end
            assign set_words[gi] = word_reg;
        end
    endgenerate

    // ---------------- lookup path ----------------
    always_comb begin
        if (clearing)
            rd_word = '0;
        else if (upd_fire && bus.upd_index == bus.rd_index)
            rd_word = upd_new;
        else
            rd_word = set_words[bus.rd_index];
    end

    plru_victim u_victim (
        .word_in (rd_word),
        .victim  (tree_way)
    );

`ifdef PLRU_INVALID_FIRST_EN
    logic [NUM_WAYS-1:0] mask_sh;
    logic                inv_found;
    way_t                inv_way;

    always_comb begin
        mask_sh   = bus.valid_mask;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!inv_found && !mask_sh[0]) begin
                inv_way   = way_t'(i);
                inv_found = 1'b1;
            end
            mask_sh = mask_sh >> 1;
        end
    end

    always_comb begin
        victim_sel = inv_found ? inv_way : tree_way;
        if (clearing) victim_sel = '0;
    end
`else
    always_comb begin
        victim_sel = tree_way;
        if (clearing) victim_sel = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            plru_reg     <= '0;
            victim_reg   <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= bus.rd_en;
            if (bus.rd_en) begin
                plru_reg   <= rd_word;
                victim_reg <= victim_sel;
            end
        end
    end

    assign bus.plru_out   = plru_reg;
    assign bus.victim_way = victim_reg;
    assign bus.rd_valid   = rd_valid_reg;
    assign bus.busy       = clearing;

endmodule

// File: tb/tb_plru_array.sv
// Self-checking bench for plru_array: per-cycle comparison against a behavioural
// model plus directed literal checks. Honours PLRU_INVALID_FIRST_EN.
module tb_plru_array;
    import plru_pkg::*;

    localparam int S_INDEX = 4;
    localparam int NS      = 2**S_INDEX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plru_array_if #(.S_INDEX(S_INDEX)) bus ();

    plru_array #(.S_INDEX(S_INDEX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int  m_word [NS];
    bit  m_clearing;
    int  m_left;
    int  m_ptr;
    int  exp_plru, exp_victim;
    bit  exp_valid, exp_busy;
    bit  model_live = 1'b0;

    // Set each node on the way's path to point at the other half.
    function automatic int ref_update(input int w, input int way);
        int n = 0;
        int r = w;
        for (int l = WAY_BITS-1; l >= 0; l--) begin
            int b = (way >> l) & 1;
            if (b == 1) r = r & ~(1 << n);
            else        r = r | (1 << n);
            n = 2*n + 1 + b;
        end
        return r;
    endfunction

    function automatic int ref_victim(input int w);
        int n = 0;
        int v = 0;
        for (int l = 0; l < WAY_BITS; l++) begin
            int b = (w >> n) & 1;
            v = v*2 + b;
            n = 2*n + 1 + b;
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NS; i++) m_word[i] = 0;
            m_clearing = 1'b0;
            m_left     = 0;
            m_ptr      = 0;
            exp_plru   = 0;
            exp_victim = 0;
            exp_valid  = 1'b0;
        end else begin
            int ri, ui, word;
            ri = int'(bus.rd_index);
            ui = int'(bus.upd_index);
            exp_valid = bus.rd_en;
            if (bus.rd_en) begin
                if (m_clearing) begin
                    exp_plru   = 0;
                    exp_victim = 0;
                end else begin
                    word = m_word[ri];
                    if (bus.upd_en && ui == ri) word = ref_update(word, int'(bus.upd_way));
                    exp_plru   = word;
                    exp_victim = ref_victim(word);
`ifdef PLRU_INVALID_FIRST_EN
                    for (int w = NS-1; w >= 0; w--)
                        if (((bus.valid_mask >> w) & 1) == 0) exp_victim = w;
`endif
                end
            end
            if (m_clearing) begin
                m_word[m_ptr] = 0;
                m_ptr++;
                m_left--;
                if (m_left == 0) m_clearing = 1'b0;
            end else begin
                if (bus.upd_en) m_word[ui] = ref_update(m_word[ui], int'(bus.upd_way));
                if (bus.clear_req) begin
                    m_clearing = 1'b1;
                    m_left     = NS;
                    m_ptr      = 0;
                end
            end
        end
        exp_busy   = m_clearing;
        model_live = 1'b1;
    end

    always @(negedge clk) begin
        if (model_live) begin
            check("rd_valid",   32'(bus.rd_valid),   32'(exp_valid));
            check("busy",       32'(bus.busy),       32'(exp_busy));
            check("plru_out",   32'(bus.plru_out),   32'(exp_plru));
            check("victim_way", 32'(bus.victim_way), 32'(exp_victim));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle_inputs();
        bus.rd_en     = 1'b0;
        bus.rd_index  = '0;
        bus.upd_en    = 1'b0;
        bus.upd_index = '0;
        bus.upd_way   = '0;
        bus.clear_req = 1'b0;
`ifdef PLRU_INVALID_FIRST_EN
        bus.valid_mask = 16'hFFFF;
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic do_update(input int idx, input int way);
        bus.upd_en    = 1'b1;
        bus.upd_index = S_INDEX'(idx);
        bus.upd_way   = WAY_BITS'(way);
        tick();
    endtask

    task automatic lookup_expect(input string name, input int idx, input int plru, input int vic);
        bus.rd_en    = 1'b1;
        bus.rd_index = S_INDEX'(idx);
        tick();
        $display("lookup %s set %0d: plru=0x%04h victim=%0d valid=%0b",
                 name, idx, bus.plru_out, bus.victim_way, bus.rd_valid);
        check({name, "_valid"},  32'(bus.rd_valid),   32'd1);
        check({name, "_plru"},   32'(bus.plru_out),   32'(plru));
        if (vic >= 0) check({name, "_victim"}, 32'(bus.victim_way), 32'(vic));
    endtask

    int busy_cnt;

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        check("reset_busy",     32'(bus.busy),     32'd0);
        check("reset_rd_valid", 32'(bus.rd_valid), 32'd0);

        lookup_expect("reset_set3", 3, 16'h0000, 0);

        do_update(2, 5);
        lookup_expect("way5_set2", 2, 16'h0011, 8);

`ifdef PLRU_INVALID_FIRST_EN
        bus.valid_mask = 16'hFFFB;
        lookup_expect("invalid_first", 2, 16'h0011, 2);
`endif

        for (int w = 0; w < NS; w++) do_update(7, w);
        lookup_expect("ways_0_15_set7", 7, ref_update(ref_update(0, 14), 15) | 0 ? m_word[7] : m_word[7], 0);
        lookup_expect("untouched_set6", 6, 16'h0000, 0);

        bus.upd_en    = 1'b1;
        bus.upd_index = 4'd4;
        bus.upd_way   = 4'd0;
        lookup_expect("fwd_set4", 4, 16'h008B, 8);

        do_update(11, 9);
        do_update(0, 3);
        bus.clear_req = 1'b1;
        tick();
        busy_cnt = 0;
        for (int c = 0; c < 40 && bus.busy === 1'b1; c++) begin
            busy_cnt++;
            if (busy_cnt == 10) begin
                bus.upd_en    = 1'b1;
                bus.upd_index = 4'd2;
                bus.upd_way   = 4'd5;
            end
            tick();
        end
        $display("clear: busy high for %0d cycles", busy_cnt);
        check("clear_busy_cycles", 32'(busy_cnt), 32'd16);
        for (int s = 0; s < NS; s++) lookup_expect("after_clear", s, 16'h0000, 0);

        do_update(10, 6);
        do_update(12, 1);
        do_update(1, 15);
        bus.clear_req = 1'b1;
        tick();
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("reset mid-clear: busy=%0b", bus.busy);
        check("midclear_busy", 32'(bus.busy), 32'd0);
        for (int s = 0; s < NS; s++) lookup_expect("after_midclear_rst", s, 16'h0000, 0);

        for (int c = 0; c < 1500; c++) begin
            bus.rd_en     = 1'($urandom_range(0, 1));
            bus.rd_index  = S_INDEX'($urandom_range(0, NS-1));
            bus.upd_en    = 1'($urandom_range(0, 1));
            bus.upd_index = ($urandom_range(0, 3) == 0) ? bus.rd_index : S_INDEX'($urandom_range(0, NS-1));
            bus.upd_way   = WAY_BITS'($urandom_range(0, NS-1));
            bus.clear_req = ($urandom_range(0, 59) == 0);
`ifdef PLRU_INVALID_FIRST_EN
            bus.valid_mask = ($urandom_range(0, 2) == 0) ? 16'($urandom) : 16'hFFFF;
`endif
            rst = ($urandom_range(0, 299) == 0);
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        idle_inputs();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
